packet_buffer_arbiter: RTL and testbench

PACKET_BUFFER_ARBITER -- requirements
Module: packet_buffer_arbiter

---
 rtl/packet_buffer_arbiter_pkg.sv | 16 +
 rtl/packet_buffer_arbiter_picker.sv | 27 ++
 rtl/packet_buffer_arbiter.sv | 103 ++++++++++
 tb/tb_packet_buffer_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_buffer_arbiter_pkg.sv
// Shared constants for the packet buffer arbiter.
// Port count, datapath widths and arbiter state encodings.
package packet_buffer_arbiter_pkg;

  localparam int NUM_PORTS = 4;
  localparam int DATA_W    = 64;
  localparam int ROUTE_W   = 24;
  localparam int GRANT_W   = 2;

  localparam logic [1:0] ARB_IDLE    = 2'b00;
  localparam logic [1:0] ARB_GRANT   = 2'b01;
  localparam logic [1:0] ARB_RELEASE = 2'b10;

  typedef logic [GRANT_W-1:0] grant_t;

endpackage

// File: rtl/packet_buffer_arbiter_picker.sv
// Round-robin priority picker: searches upward from last_grant+1.
// Purely combinational; valid is low when no port requests.
module rr_priority_picker
  import packet_buffer_arbiter_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  grant_t               last_grant,
  output grant_t               winner,
  output logic                 valid
);

  // Walk from farthest to nearest so the nearest requester wins last.
  always_comb begin
    grant_t idx;
    idx    = last_grant;
    winner = last_grant;
    valid  = 1'b0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      idx = last_grant + GRANT_W'(i);
      if (req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/packet_buffer_arbiter.sv
// Packet buffer arbiter: round-robin grant of one requester at a time,
// forwarding its word stream and counting completed packets.
module packet_buffer_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 64,
  parameter int ROUTE_W   = 24
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_PORTS-1:0]         in_req,
  output logic [NUM_PORTS-1:0]         in_ack,
  input  logic [NUM_PORTS*DATA_W-1:0]  in_data,
  input  logic [NUM_PORTS*ROUTE_W-1:0] in_pkt_route,
  input  logic [NUM_PORTS-1:0]         in_wr,
  input  logic [NUM_PORTS-1:0]         in_bop,
  input  logic [NUM_PORTS-1:0]         in_eop,
  output logic [NUM_PORTS-1:0]         in_rdy,
  output logic [DATA_W-1:0]            out_data,
  output logic [ROUTE_W-1:0]           out_pkt_route,
  output logic                         out_wr,
  output logic                         out_bop,
  output logic                         out_eop,
  input  logic                         out_rdy,
  output logic [1:0]                   out_grant,
  output logic                         out_busy,
  output logic [15:0]                  pkt_count
);

  import packet_buffer_arbiter_pkg::ARB_IDLE;
  import packet_buffer_arbiter_pkg::ARB_GRANT;
  import packet_buffer_arbiter_pkg::ARB_RELEASE;
  import packet_buffer_arbiter_pkg::grant_t;

  logic [1:0] state;
  grant_t     last_grant;
  grant_t     winner;
  logic       win_valid;
  logic       granted;

  rr_priority_picker u_picker (
    .req        (in_req),
    .last_grant (last_grant),
    .winner     (winner),
    .valid      (win_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARB_IDLE;
      last_grant <= 2'd3;
      out_grant  <= 2'd0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (win_valid) begin
            state      <= ARB_GRANT;
            out_grant  <= winner;
            last_grant <= winner;
          end
        end
        ARB_GRANT: begin
          if (!in_req[out_grant]) state <= ARB_RELEASE;
        end
        ARB_RELEASE: state <= ARB_IDLE;
        default:     state <= ARB_IDLE;
      endcase
    end
  end

  assign granted  = (state == ARB_GRANT);
  assign out_busy = granted;

  // Ack and datapath decode from state so reset drops them at once.
  always_comb begin
    in_ack        = '0;
    in_rdy        = '0;
    out_data      = '0;
    out_pkt_route = '0;
    out_wr        = 1'b0;
    out_bop       = 1'b0;
    out_eop       = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (granted && out_grant == 2'(i)) begin
        in_ack[i]     = 1'b1;
        in_rdy[i]     = out_rdy;
        out_data      = in_data[i*DATA_W +: DATA_W];
        out_pkt_route = in_pkt_route[i*ROUTE_W +: ROUTE_W];
        out_wr        = in_wr[i];
        out_bop       = in_bop[i];
        out_eop       = in_eop[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_count <= 16'd0;
    end else if (out_wr && out_eop) begin
      pkt_count <= pkt_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_packet_buffer_arbiter.sv
// Scoreboard bench for packet_buffer_arbiter: directed scenarios push
// expected grants/words; a negedge monitor pops and compares.
module tb_packet_buffer_arbiter;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   in_req = '0;
  logic [3:0]   in_ack;
  logic [255:0] in_data = '0;
  logic [95:0]  in_pkt_route = '0;
  logic [3:0]   in_wr = '0;
  logic [3:0]   in_bop = '0;
  logic [3:0]   in_eop = '0;
  logic [3:0]   in_rdy;
  logic [63:0]  out_data;
  logic [23:0]  out_pkt_route;
  logic         out_wr;
  logic         out_bop;
  logic         out_eop;
  logic         out_rdy = 1'b1;
  logic [1:0]   out_grant;
  logic         out_busy;
  logic [15:0]  pkt_count;

  packet_buffer_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .in_req        (in_req),
    .in_ack        (in_ack),
    .in_data       (in_data),
    .in_pkt_route  (in_pkt_route),
    .in_wr         (in_wr),
    .in_bop        (in_bop),
    .in_eop        (in_eop),
    .in_rdy        (in_rdy),
    .out_data      (out_data),
    .out_pkt_route (out_pkt_route),
    .out_wr        (out_wr),
    .out_bop       (out_bop),
    .out_eop       (out_eop),
    .out_rdy       (out_rdy),
    .out_grant     (out_grant),
    .out_busy      (out_busy),
    .pkt_count     (pkt_count)
  );

  always #5 clk = ~clk;

  logic [89:0] exp_words[$];
  int          exp_grants[$];
  int          checks = 0;
  int          failures = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Monitor: words on out_wr, grants on rising in_ack.
  logic [89:0] mon_w;
  int          mon_g;
  logic [3:0]  prev_ack = '0;

  always @(negedge clk) begin
    if (out_wr) begin
      if (exp_words.size() == 0) begin
        chk("word_unexpected", 64'd1, 64'd0);
      end else begin
        mon_w = exp_words.pop_front();
        chk("word_data", out_data, mon_w[89:26]);
        chk("word_ctl", {out_pkt_route, out_bop, out_eop}, mon_w[25:0]);
      end
    end
    if (in_ack != 0 && prev_ack == 0) begin
      if (exp_grants.size() == 0) begin
        chk("grant_unexpected", in_ack, 64'd0);
      end else begin
        mon_g = exp_grants.pop_front();
        chk("grant_ack", in_ack, 64'(4'b1 << mon_g));
        chk("grant_idx", out_grant, mon_g);
        chk("grant_busy", out_busy, 1);
      end
    end
    prev_ack = in_ack;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_word(int p, logic [63:0] d, logic [23:0] r,
                          logic b, logic e);
    in_data[p*64 +: 64]      = d;
    in_pkt_route[p*24 +: 24] = r;
    in_wr[p]  = 1'b1;
    in_bop[p] = b;
    in_eop[p] = e;
    exp_words.push_back({d, r, b, e});
  endtask

  task automatic clr_port(int p);
    in_data[p*64 +: 64]      = '0;
    in_pkt_route[p*24 +: 24] = '0;
    in_wr[p]  = 1'b0;
    in_bop[p] = 1'b0;
    in_eop[p] = 1'b0;
  endtask

  // Sends n words; drops in_req with the last word.
  task automatic send_pkt(int p, int n, logic [63:0] base);
    logic [63:0] d;
    for (int i = 0; i < n; i++) begin
      d = base + 64'(i);
      put_word(p, d, d[23:0] ^ 24'hA5A5A5, i == 0, i == n - 1);
      if (i == n - 1) in_req[p] = 1'b0;
      tick();
    end
    clr_port(p);
  endtask

  task automatic wait_ack(int p, output int lows);
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      if (in_ack != 0) break;
      lows++;
      tick();
    end
    chk("wait_ack", in_ack, 64'(4'b1 << p));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    int e;
    int acks;

    // Reset state
    tick();
    tick();
    chk("rst_ack", in_ack, 0);
    chk("rst_grant", out_grant, 0);
    chk("rst_cnt", pkt_count, 0);
    chk("rst_busy", out_busy, 0);
    chk("rst_wr", out_wr, 0);
    reset = 1'b0;
    tick();

    // Single requester, 3-word packet
    in_req = 4'b0100;
    exp_grants.push_back(2);
    tick();
    chk("s1_latency", in_ack, 4'b0100);
    send_pkt(2, 3, 64'h1000);
    chk("s1_cnt", pkt_count, 1);

    // All four requesting: order 0,1,2,3,0 with 2-cycle gaps
    do_reset();
    in_req = 4'b1111;
    for (int k = 0; k < 5; k++) exp_grants.push_back(k % 4);
    for (int k = 0; k < 5; k++) begin
      e = k % 4;
      wait_ack(e, lows);
      if (k > 0) chk("s2_gap", lows, 2);
      send_pkt(e, 1, 64'h2000 + 64'(k));
      if (k < 4) in_req[e] = 1'b1;
      else in_req = 4'b0000;
    end
    chk("s2_cnt", pkt_count, 5);

    // Port 1 granted, port 2 strobes must be ignored
    in_req[1] = 1'b1;
    exp_grants.push_back(1);
    wait_ack(1, lows);
    for (int i = 0; i < 3; i++) begin
      put_word(1, 64'h3000 + 64'(i), 24'h310000 + 24'(i), i == 0, i == 2);
      in_data[2*64 +: 64] = 64'hDEAD_0000 + 64'(i);
      in_pkt_route[2*24 +: 24] = 24'hEEEEEE;
      in_wr[2]  = 1'b1;
      in_bop[2] = 1'b1;
      in_eop[2] = 1'b1;
      if (i == 2) in_req[1] = 1'b0;
      #1;
      chk("s3_rdy2", in_rdy[2], 0);
      chk("s3_rdy1", in_rdy[1], 1);
      tick();
    end
    clr_port(1);
    clr_port(2);
    chk("s3_cnt", pkt_count, 6);

    // out_rdy stall for 5 cycles mid-packet
    in_req[3] = 1'b1;
    exp_grants.push_back(3);
    wait_ack(3, lows);
    put_word(3, 64'h4000, 24'h400000, 1'b1, 1'b0);
    tick();
    put_word(3, 64'h4001, 24'h400001, 1'b0, 1'b0);
    tick();
    clr_port(3);
    out_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("s4_stall_rdy", in_rdy, 0);
      tick();
    end
    out_rdy = 1'b1;
    #1;
    chk("s4_resume_rdy", in_rdy, 4'b1000);
    put_word(3, 64'h4002, 24'h400002, 1'b0, 1'b0);
    tick();
    put_word(3, 64'h4003, 24'h400003, 1'b0, 1'b1);
    in_req[3] = 1'b0;
    tick();
    clr_port(3);
    chk("s4_cnt", pkt_count, 7);

    // Reset on word 2 of 4, then port 0 beats port 3
    in_req[2] = 1'b1;
    exp_grants.push_back(2);
    wait_ack(2, lows);
    put_word(2, 64'h5000, 24'h500000, 1'b1, 1'b0);
    tick();
    in_data[2*64 +: 64] = 64'h5001;
    in_wr[2] = 1'b1;
    reset = 1'b1;
    #1;
    chk("s5_ack_async", in_ack, 0);
    chk("s5_busy_async", out_busy, 0);
    chk("s5_wr_async", out_wr, 0);
    chk("s5_cnt_async", pkt_count, 0);
    clr_port(2);
    in_req = 4'b1001;
    tick();
    tick();
    reset = 1'b0;
    exp_grants.push_back(0);
    exp_grants.push_back(3);
    wait_ack(0, lows);
    send_pkt(0, 1, 64'h5100);
    wait_ack(3, lows);
    send_pkt(3, 1, 64'h5200);
    chk("s5_cnt", pkt_count, 2);

    // Request raised and dropped between edges is never granted
    tick();
    in_req[1] = 1'b1;
    #3;
    in_req[1] = 1'b0;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (in_ack != 0) acks++;
    end
    chk("s5_unsampled_req", acks, 0);

    // Counter wrap: 65536 single-word packets in one grant
    do_reset();
    in_req[0] = 1'b1;
    exp_grants.push_back(0);
    wait_ack(0, lows);
    for (int i = 0; i < 65535; i++) begin
      put_word(0, 64'(i), 24'h600000, 1'b1, 1'b1);
      tick();
    end
    chk("s6_cnt_max", pkt_count, 16'hFFFF);
    put_word(0, 64'hFFFF_0000, 24'h6FFFFF, 1'b1, 1'b1);
    in_req[0] = 1'b0;
    tick();
    clr_port(0);
    chk("s6_cnt_wrap", pkt_count, 0);

    repeat (3) tick();
    chk("sb_words_left", exp_words.size(), 0);
    chk("sb_grants_left", exp_grants.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
